irq_capture_4: RTL and testbench
================================

# irq_capture_4

Four-line interrupt capture stage placed directly upstream of the 4-to-2 priority encoder. It synchronises asynchronous request lines, detects events, and holds each event in a pending latch until downstream service logic clears it. It drives the encoder's 4-bit `in` vector with the unmasked pending set. The encoder's `out` index is fed back here as the clear index once the request is serviced.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each input synchroniser; legal range 2–4.
- `LEVEL_MODE`, default 0: 0 = rising-edge capture with pending latch; 1 = pending mirrors the synchronised level.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `irq_in`  in  4  asynchronous interrupt request lines.
- `mask`  in  4  synchronous; 1 hides the bit from `masked_pending`.
- `clr_valid`  in  1  clear strobe, one cycle per clear.
- `clr_idx`  in  2  index of the pending bit to clear; the encoder `out` value.
- `ovf_clr`  in  1  clears all `overflow` flags.
- `pending`  out  4  registered pending latches.
- `masked_pending`  out  4  `pending & ~mask`; connects to the encoder `in`.
- `any_pending`  out  1  OR of `masked_pending`; mirrors the encoder `valid`.
- `overflow`  out  4  sticky flag: an event arrived while the bit was already pending.

## Operation
- **Synchroniser, per bit:** `SYNC_STAGES` flops, then one history flop `prev`.
- **Edge detect:** `rise[i] = sync_last[i] & ~prev[i]`.
- **Edge mode (`LEVEL_MODE`=0), next state of `pending[i]`:**
  - `set` = `rise[i]`.
  - `clr` = `clr_valid & (clr_idx == i)`.
  - `set` → 1, regardless of `clr`. Set wins, so a new event is never lost.
  - `clr` without `set` → 0.
  - Otherwise hold.
- **Overflow:** `overflow[i]` sets when `rise[i] & pending[i] & ~clr`.
  - A rise on the same bit and cycle as its clear is not an overflow.
  - `ovf_clr` zeroes all flags. If `ovf_clr` and a new overflow coincide, the new overflow wins.
- **Level mode (`LEVEL_MODE`=1):**
  - `pending[i]` <= `sync_last[i]` each cycle.
  - `clr_valid` and `clr_idx` are ignored.
  - `overflow` stays 0.
- **Mask:**
  - Masking does not stop latching. A masked event is held, and appears on `masked_pending` when unmasked.
  - `mask` acts combinationally on `masked_pending` and `any_pending`.
- **Clearing a non-pending bit:** no effect, no error.
- **Reset (`rst_n`=0), asynchronous, at any time including mid-service:**
  - Synchronisers, `prev`, `pending` and `overflow` all clear to 0 immediately.
  - `masked_pending` and `any_pending` go to 0 within the same cycle.
- **After reset release:** a line already high counts as a fresh rising edge, because `prev` resets to 0.

## Timing
- **Capture latency:** `irq_in[i]` is first sampled high at edge k; `pending[i]` is 1 after edge k+`SYNC_STAGES`. Default: visible 2 cycles after the first sampling edge, i.e. after edge k+2.
- **Minimum pulse width:** `irq_in` pulses must be at least 1 clk period plus setup time. Narrower pulses may be missed.
- **Clear latency:** `clr_valid` sampled at edge n → `pending` bit is 0 after edge n.
  - `masked_pending` is combinational from the registers, so the encoder sees the next winner in cycle n+1.
- **Back-to-back clears:** one per cycle is legal.
- **Steady-state levels:** a held-high line generates exactly one event. A second event requires the line to go low for at least 1 synchronised cycle.
- **Reset values:** every output is 0 throughout reset.

## Test plan
- **Reset and idle:** hold `rst_n`=0, then release with `irq_in`=0000. Expect `pending`=0000, `any_pending`=0 and `overflow`=0000 for 10 cycles.
- **Single capture and clear:** pulse `irq_in`=0010 for 1 cycle. Expect `pending`=0010 after 2 edges and `any_pending`=1. Apply `clr_valid`=1, `clr_idx`=1. Expect `pending`=0000 the next cycle.
- **Multiple pending with encoder in loop:** raise `irq_in`=1101 together. Expect `masked_pending`=1101 and encoder `out`=3. Clear 3 → `out`=2; clear 2 → `out`=0; clear 0 → `any_pending`=0.
- **Mask:**
  - `mask`=1000, event on bit 3 → `pending`=1000, `masked_pending`=0000, `any_pending`=0.
  - Drop the mask → `masked_pending`=1000 in the same cycle.
- **Overflow and set-wins:**
  - Two edges on bit 0 with no clear → `overflow`=0001; `ovf_clr` → 0000.
  - Align a new edge with `clr_idx`=0 → `pending[0]` stays 1 and `overflow`=0000.
- **Mid-operation reset and level mode:**
  - With `pending`=0110, pulse `rst_n` low mid-cycle → all outputs 0 before the next edge.
  - `LEVEL_MODE`=1: `pending` tracks `irq_in` with 2-cycle delay; `clr_valid` has no effect.

Source files
------------

// File: rtl/irq_capture_4.sv
// Four-line interrupt capture: synchronise, edge-detect and latch requests
// ahead of the 4-to-2 priority encoder, with sticky per-line overflow flags.
module irq_capture_4 #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          LEVEL_MODE  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq_in,
    input  logic [3:0] mask,
    input  logic       clr_valid,
    input  logic [1:0] clr_idx,
    input  logic       ovf_clr,
    output logic [3:0] pending,
    output logic [3:0] masked_pending,
    output logic       any_pending,
    output logic [3:0] overflow
);

    localparam int unsigned NUM_IRQ = 4;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_last;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr_hit;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] overflow_d;

    // First synchroniser stage samples the asynchronous request lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q[0] <= '0;
        end else begin
            sync_q[0] <= irq_in;
        end
    end

    for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_sync
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q[s] <= '0;
            end else begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    // prev resets to 0, so a line already high at reset release reads as a rise
    assign rise      = sync_last & ~prev_q;

    always_comb begin
        clr_hit = '0;
        if (clr_valid) begin
            clr_hit[clr_idx] = 1'b1;
        end
    end

    // Set beats clear so an event arriving during service is never dropped
    always_comb begin
        pending_d  = '0;
        overflow_d = '0;
        if (LEVEL_MODE) begin
            pending_d  = sync_last;
            overflow_d = '0;
        end else begin
            pending_d  = rise | (pending & ~clr_hit);
            overflow_d = (rise & pending & ~clr_hit)
                       | (overflow & ~{NUM_IRQ{ovf_clr}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            prev_q   <= sync_last;
            pending  <= pending_d;
            overflow <= overflow_d;
        end
    end

    assign masked_pending = pending & ~mask;
    assign any_pending    = |masked_pending;

endmodule

// File: tb/tb_irq_capture_4.sv
// Directed self-checking bench for irq_capture_4 in edge and level modes.
module tb_irq_capture_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic       clr_valid;
    logic [1:0] clr_idx;
    logic       ovf_clr;

    logic [3:0] pending,   masked_pending,   overflow;
    logic       any_pending;
    logic [3:0] l_pending, l_masked_pending, l_overflow;
    logic       l_any_pending;

    int vec_cnt;
    int err_cnt;

    irq_capture_4 #(.SYNC_STAGES(2), .LEVEL_MODE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask),
        .clr_valid(clr_valid), .clr_idx(clr_idx), .ovf_clr(ovf_clr),
        .pending(pending), .masked_pending(masked_pending),
        .any_pending(any_pending), .overflow(overflow)
    );

    irq_capture_4 #(.SYNC_STAGES(2), .LEVEL_MODE(1'b1)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask),
        .clr_valid(clr_valid), .clr_idx(clr_idx), .ovf_clr(ovf_clr),
        .pending(l_pending), .masked_pending(l_masked_pending),
        .any_pending(l_any_pending), .overflow(l_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set index wins, as in the downstream encoder
    function automatic logic [1:0] enc(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse, then wait until the capture is visible
    task automatic pulse(input logic [3:0] bits);
        irq_in = bits;
        tick();
        irq_in = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; irq_in = '0; mask = '0;
        clr_valid = 1'b0; clr_idx = '0; ovf_clr = 1'b0;
        tick(); tick();
        vec_cnt++;
        if ({pending, any_pending, overflow} !== 9'd0) begin
            err_cnt++;
            $display("FAIL reset_hold: pending=%b any=%b ovf=%b, want 0", pending, any_pending, overflow);
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            vec_cnt++;
            if (pending !== 4'b0000 || any_pending !== 1'b0 || overflow !== 4'b0000) begin
                err_cnt++;
                $display("FAIL idle_c%0d: pending=%b any=%b ovf=%b, want 0000/0/0000", c, pending, any_pending, overflow);
            end
        end
    endtask

    task automatic test_single;
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        tick();
        vec_cnt++;
        if (pending !== 4'b0000) begin
            err_cnt++;
            $display("FAIL single_early: pending=%b, want 0000", pending);
        end
        tick();
        vec_cnt++;
        if (pending !== 4'b0010 || any_pending !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_capture: pending=%b any=%b, want 0010/1", pending, any_pending);
        end
        clr_valid = 1'b1; clr_idx = 2'd1;
        tick();
        clr_valid = 1'b0;
        vec_cnt++;
        if (pending !== 4'b0000 || any_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_clear: pending=%b any=%b, want 0000/0", pending, any_pending);
        end
    endtask

    task automatic test_back_to_back;
        pulse(4'b1101);
        vec_cnt++;
        if (masked_pending !== 4'b1101 || enc(masked_pending) !== 2'd3) begin
            err_cnt++;
            $display("FAIL multi_capture: masked=%b out=%0d, want 1101/3", masked_pending, enc(masked_pending));
        end
        clr_valid = 1'b1; clr_idx = 2'd3;
        tick();
        vec_cnt++;
        if (masked_pending !== 4'b0101 || enc(masked_pending) !== 2'd2) begin
            err_cnt++;
            $display("FAIL multi_clr3: masked=%b out=%0d, want 0101/2", masked_pending, enc(masked_pending));
        end
        clr_idx = 2'd2;
        tick();
        vec_cnt++;
        if (masked_pending !== 4'b0001 || enc(masked_pending) !== 2'd0) begin
            err_cnt++;
            $display("FAIL multi_clr2: masked=%b out=%0d, want 0001/0", masked_pending, enc(masked_pending));
        end
        clr_idx = 2'd0;
        tick();
        clr_valid = 1'b0;
        vec_cnt++;
        if (any_pending !== 1'b0 || pending !== 4'b0000 || overflow !== 4'b0000) begin
            err_cnt++;
            $display("FAIL multi_clr0: pending=%b any=%b ovf=%b, want 0000/0/0000", pending, any_pending, overflow);
        end
    endtask

    task automatic test_mask;
        mask = 4'b1000;
        pulse(4'b1000);
        vec_cnt++;
        if (pending !== 4'b1000 || masked_pending !== 4'b0000 || any_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL mask_hold: pending=%b masked=%b any=%b, want 1000/0000/0", pending, masked_pending, any_pending);
        end
        #1 mask = 4'b0000;
        #1;
        vec_cnt++;
        if (masked_pending !== 4'b1000 || any_pending !== 1'b1) begin
            err_cnt++;
            $display("FAIL mask_drop: masked=%b any=%b, want 1000/1", masked_pending, any_pending);
        end
        clr_valid = 1'b1; clr_idx = 2'd3;
        tick();
        clr_valid = 1'b0;
        vec_cnt++;
        if (pending !== 4'b0000) begin
            err_cnt++;
            $display("FAIL mask_clear: pending=%b, want 0000", pending);
        end
    endtask

    task automatic test_overflow;
        pulse(4'b0001);
        pulse(4'b0001);
        vec_cnt++;
        if (overflow !== 4'b0001 || pending !== 4'b0001) begin
            err_cnt++;
            $display("FAIL ovf_set: ovf=%b pending=%b, want 0001/0001", overflow, pending);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vec_cnt++;
        if (overflow !== 4'b0000 || pending !== 4'b0001) begin
            err_cnt++;
            $display("FAIL ovf_clr: ovf=%b pending=%b, want 0000/0001", overflow, pending);
        end
        // New rise lands in the same cycle as the clear of bit 0
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        tick();
        clr_valid = 1'b1; clr_idx = 2'd0;
        tick();
        clr_valid = 1'b0;
        vec_cnt++;
        if (pending !== 4'b0001 || overflow !== 4'b0000) begin
            err_cnt++;
            $display("FAIL set_wins: pending=%b ovf=%b, want 0001/0000", pending, overflow);
        end
        clr_valid = 1'b1; clr_idx = 2'd0;
        tick();
        clr_valid = 1'b0;
        vec_cnt++;
        if (pending !== 4'b0000) begin
            err_cnt++;
            $display("FAIL set_wins_clr: pending=%b, want 0000", pending);
        end
    endtask

    task automatic test_release_held;
        rst_n = 1'b0;
        irq_in = 4'b0100;
        tick();
        #2 rst_n = 1'b1;
        tick();
        tick();
        vec_cnt++;
        if (pending !== 4'b0000) begin
            err_cnt++;
            $display("FAIL held_early: pending=%b, want 0000", pending);
        end
        tick();
        vec_cnt++;
        if (pending !== 4'b0100) begin
            err_cnt++;
            $display("FAIL held_capture: pending=%b, want 0100", pending);
        end
        clr_valid = 1'b1; clr_idx = 2'd2;
        tick();
        clr_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        vec_cnt++;
        if (pending !== 4'b0000 || overflow !== 4'b0000) begin
            err_cnt++;
            $display("FAIL held_single_event: pending=%b ovf=%b, want 0000/0000", pending, overflow);
        end
        irq_in = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_mid_reset;
        pulse(4'b0110);
        vec_cnt++;
        if (pending !== 4'b0110) begin
            err_cnt++;
            $display("FAIL midrst_setup: pending=%b, want 0110", pending);
        end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (pending !== 4'b0000 || masked_pending !== 4'b0000 || any_pending !== 1'b0 ||
            overflow !== 4'b0000 || l_pending !== 4'b0000 || l_any_pending !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_async: pending=%b masked=%b any=%b ovf=%b lvl=%b, want all 0",
                     pending, masked_pending, any_pending, overflow, l_pending);
        end
        tick();
    endtask

    task automatic test_level;
        rst_n = 1'b1;
        irq_in = 4'b0000;
        tick(); tick(); tick();
        irq_in = 4'b0101;
        clr_valid = 1'b1; clr_idx = 2'd0;
        tick();
        tick();
        vec_cnt++;
        if (l_pending !== 4'b0000) begin
            err_cnt++;
            $display("FAIL level_early: pending=%b, want 0000", l_pending);
        end
        tick();
        vec_cnt++;
        if (l_pending !== 4'b0101 || l_any_pending !== 1'b1) begin
            err_cnt++;
            $display("FAIL level_rise: pending=%b any=%b, want 0101/1", l_pending, l_any_pending);
        end
        tick();
        vec_cnt++;
        if (l_pending !== 4'b0101) begin
            err_cnt++;
            $display("FAIL level_clr_ignored: pending=%b, want 0101", l_pending);
        end
        clr_valid = 1'b0;
        irq_in = 4'b0000;
        tick(); tick();
        vec_cnt++;
        if (l_pending !== 4'b0101) begin
            err_cnt++;
            $display("FAIL level_fall_early: pending=%b, want 0101", l_pending);
        end
        tick();
        vec_cnt++;
        if (l_pending !== 4'b0000 || l_overflow !== 4'b0000) begin
            err_cnt++;
            $display("FAIL level_fall: pending=%b ovf=%b, want 0000/0000", l_pending, l_overflow);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_overflow();
        test_release_held();
        test_mid_reset();
        test_level();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
